// File: rtl/elevator_car_ctrl_pkg.sv
// Shared types and helpers for the elevator car controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_car_ctrl_pkg;

    localparam int N_FLOORS = 3;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    function automatic logic [N_FLOORS-1:0] floor_leds(input floor_t f);
        case (f)
            2'd0:    floor_leds = 3'b001;
            2'd1:    floor_leds = 3'b010;
            default: floor_leds = 3'b100;
        endcase
    endfunction

    function automatic logic reqs_above(input logic [N_FLOORS-1:0] p, input floor_t f);
        case (f)
            2'd0:    reqs_above = |p[2:1];
            2'd1:    reqs_above = p[2];
            default: reqs_above = 1'b0;
        endcase
    endfunction

    function automatic logic reqs_below(input logic [N_FLOORS-1:0] p, input floor_t f);
        case (f)
            2'd0:    reqs_below = 1'b0;
            2'd1:    reqs_below = p[0];
            default: reqs_below = |p[1:0];
        endcase
    endfunction

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Call/step inputs and car status outputs of the elevator controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels.
interface elevator_car_ctrl_if;
    logic [elevator_car_ctrl_pkg::N_FLOORS-1:0] call;
    logic                                       step_clk;
    logic                                       moving;
    logic                                       dir_up;
    logic                                       door_open;
    logic                                       led1;
    logic                                       led2;
    logic                                       led3;
    logic [elevator_car_ctrl_pkg::N_FLOORS-1:0] pending;

    modport master (
        output call, step_clk,
        input  moving, dir_up, door_open, led1, led2, led3, pending
    );

    modport slave (
        input  call, step_clk,
        output moving, dir_up, door_open, led1, led2, led3, pending
    );
endinterface

// File: rtl/elevator_car_ctrl_step_edge_det.sv
// Rising-edge pulse from the divided step clock (same clock domain).
// Latency: tick is combinational from step_clk against a 1-cycle history flop.
// Backpressure: none.
module elevator_car_ctrl_step_edge_det (
    input  logic clk_50,
    input  logic reset_n,
    input  logic step_clk,
    output logic tick
);
    logic step_q;
    logic step_d;

    always_comb step_d = step_clk;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) step_q <= 1'b0;
        else          step_q <= step_d;
    end

    assign tick = step_clk & ~step_q;
endmodule

// File: rtl/elevator_car_ctrl.sv
// Three-floor collective up/down car scheduler with travel and door timers.
// Latency: calls are latched in 1 cycle; all outputs decode from registered state.
// Backpressure: none; calls are level-sampled every cycle.
module elevator_car_ctrl
    import elevator_car_ctrl_pkg::*;
#(
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_CYCLES  = 150000000
) (
    input  logic               clk_50,
    input  logic               reset_n,
    elevator_car_ctrl_if.slave bus
);
    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);

    state_t                state_q, state_d;
    floor_t                floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]         door_cnt_q, door_cnt_d;

    logic                  tick;
    logic [N_FLOORS-1:0]   cur_mask, new_mask;
    logic                  here, going_up, ahead;

    elevator_car_ctrl_step_edge_det u_step_edge_det (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .step_clk (bus.step_clk),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        pending_d  = pending_q | bus.call;
        tick_cnt_d = tick_cnt_q;
        door_cnt_d = door_cnt_q;
        cur_mask   = floor_leds(floor_q);
        new_mask   = cur_mask;
        here       = |((pending_q | bus.call) & cur_mask);
        going_up   = (state_q == MOVE_UP);
        ahead      = 1'b0;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (here) begin
                    state_d    = DOOR_OPEN;
                    door_cnt_d = DOOR_LOAD;
                    pending_d  = pending_d & ~cur_mask;
                end else if (reqs_above(pending_q, floor_q) &&
                             (dir_up_q || !reqs_below(pending_q, floor_q))) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (reqs_below(pending_q, floor_q)) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // Clamp at the end floors so the car can never leave the shaft.
                        if (going_up) floor_d = (floor_q == 2'd2) ? floor_q : floor_q + 2'd1;
                        else          floor_d = (floor_q == 2'd0) ? floor_q : floor_q - 2'd1;
                        new_mask = floor_leds(floor_d);
                        ahead    = going_up ? reqs_above(pending_d, floor_d)
                                            : reqs_below(pending_d, floor_d);
                        if (|(pending_d & new_mask)) begin
                            state_d    = DOOR_OPEN;
                            door_cnt_d = DOOR_LOAD;
                            pending_d  = pending_d & ~new_mask;
                        end else if (!ahead) begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end

            DOOR_OPEN: begin
                pending_d = pending_q | (bus.call & ~cur_mask);
                if (|(bus.call & cur_mask)) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (door_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    door_cnt_d = door_cnt_q - DW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            floor_q    <= 2'd0;
            dir_up_q   <= 1'b1;
            pending_q  <= '0;
            tick_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_up_q   <= dir_up_d;
            pending_q  <= pending_d;
            tick_cnt_q <= tick_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign bus.moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign bus.door_open = (state_q == DOOR_OPEN);
    assign bus.dir_up    = dir_up_q;
    assign bus.pending   = pending_q;
    assign {bus.led3, bus.led2, bus.led1} = floor_leds(floor_q);
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed scenario bench for elevator_car_ctrl (TRAVEL_TICKS=2, DOOR_CYCLES=8).
module tb_elevator_car_ctrl;
    logic clk_50  = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    logic [2:0] leds;

    elevator_car_ctrl_if bus();

    elevator_car_ctrl #(.TRAVEL_TICKS(2), .DOOR_CYCLES(8)) dut (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_50 = ~clk_50;
    assign leds = {bus.led3, bus.led2, bus.led1};

    // Step clock toggles every 4 clk_50 cycles; the DUT ignores its edges unless moving.
    initial begin
        bus.step_clk = 1'b0;
        forever begin
            repeat (4) @(posedge clk_50);
            #1 bus.step_clk = ~bus.step_clk;
        end
    end

    task automatic step();
        @(posedge clk_50); #1;
    endtask

    task automatic wait_leds(input logic [2:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (leds === want) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_moving(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.moving === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Counts consecutive samples (including the current one) with the door open.
    task automatic wait_door_closed(input int budget, output int n);
        n = 0;
        while (bus.door_open === 1'b1 && n < budget) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        bus.call = 3'b100;
        repeat (3) @(posedge clk_50);
        #1;
        checks++; if (bus.moving !== 1'b0)    begin errors++; $display("FAIL rst_moving: got %b want 0", bus.moving); end
        checks++; if (bus.dir_up !== 1'b1)    begin errors++; $display("FAIL rst_dir_up: got %b want 1", bus.dir_up); end
        checks++; if (bus.door_open !== 1'b0) begin errors++; $display("FAIL rst_door: got %b want 0", bus.door_open); end
        checks++; if (leds !== 3'b001)        begin errors++; $display("FAIL rst_leds: got %b want 001", leds); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL rst_pending: got %b want 000", bus.pending); end
        reset_n = 1'b1;
        step();
        checks++; if (bus.moving !== 1'b0)    begin errors++; $display("FAIL rel_idle_moving: got %b want 0", bus.moving); end
        checks++; if (bus.pending !== 3'b100) begin errors++; $display("FAIL rel_pending: got %b want 100", bus.pending); end
        step();
        checks++; if (bus.moving !== 1'b1)    begin errors++; $display("FAIL rel_move_up: got %b want 1", bus.moving); end
        checks++; if (bus.dir_up !== 1'b1)    begin errors++; $display("FAIL rel_dir_up: got %b want 1", bus.dir_up); end
        bus.call = 3'b000;
    endtask

    task automatic test_up_trip();
        bit ok; int n;
        wait_leds(3'b010, 100, ok);
        checks++; if (!ok)                    begin errors++; $display("FAIL up_reach_f1: timeout, leds %b want 010", leds); end
        checks++; if (bus.moving !== 1'b1)    begin errors++; $display("FAIL up_f1_moving: got %b want 1", bus.moving); end
        wait_leds(3'b100, 100, ok);
        checks++; if (!ok)                    begin errors++; $display("FAIL up_reach_f2: timeout, leds %b want 100", leds); end
        checks++; if (bus.moving !== 1'b0)    begin errors++; $display("FAIL up_f2_moving: got %b want 0", bus.moving); end
        checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL up_f2_door: got %b want 1", bus.door_open); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL up_f2_pending: got %b want 000", bus.pending); end
        wait_door_closed(100, n);
        checks++; if (n !== 8)                begin errors++; $display("FAIL up_door_len: got %0d want 8", n); end
        checks++; if (bus.moving !== 1'b0 || leds !== 3'b100) begin errors++; $display("FAIL up_idle: moving %b leds %b want 0/100", bus.moving, leds); end
    endtask

    task automatic test_down_pass();
        bit ok; int n;
        bus.call = 3'b001; step(); bus.call = 3'b000;
        wait_moving(20, ok);
        checks++; if (!ok)                    begin errors++; $display("FAIL dn_start: timeout waiting for moving"); end
        checks++; if (bus.dir_up !== 1'b0)    begin errors++; $display("FAIL dn_dir: got %b want 0", bus.dir_up); end
        wait_leds(3'b010, 100, ok);
        checks++; if (!ok || bus.moving !== 1'b1 || bus.door_open !== 1'b0) begin errors++; $display("FAIL dn_pass_f1: ok %b moving %b door %b want 1/1/0", ok, bus.moving, bus.door_open); end
        wait_leds(3'b001, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1) begin errors++; $display("FAIL dn_f0_door: ok %b door %b want 1/1", ok, bus.door_open); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL dn_f0_pending: got %b want 000", bus.pending); end
        wait_door_closed(100, n);
        checks++; if (n !== 8)                begin errors++; $display("FAIL dn_door_len: got %0d want 8", n); end
    endtask

    task automatic test_door_hold();
        int n;
        bus.call = 3'b001;
        step();
        checks++; if (bus.door_open !== 1'b1 || bus.moving !== 1'b0) begin errors++; $display("FAIL hold_open: door %b moving %b want 1/0", bus.door_open, bus.moving); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL hold_pending: got %b want 000", bus.pending); end
        repeat (20) step();
        checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL hold_kept: got %b want 1", bus.door_open); end
        checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL hold_no_latch: got %b want 000", bus.pending); end
        bus.call = 3'b000;
        wait_door_closed(100, n);
        checks++; if (n !== 8)                begin errors++; $display("FAIL hold_tail: got %0d want 8", n); end
    endtask

    task automatic test_midtravel_call();
        bit ok; int n;
        bus.call = 3'b100; step(); bus.call = 3'b000;
        wait_moving(20, ok);
        checks++; if (!ok || bus.dir_up !== 1'b1) begin errors++; $display("FAIL mid_start: ok %b dir %b want 1/1", ok, bus.dir_up); end
        wait_leds(3'b010, 100, ok);
        bus.call = 3'b001; step(); bus.call = 3'b000;
        checks++; if (!ok || bus.pending !== 3'b101) begin errors++; $display("FAIL mid_latch: ok %b pending %b want 1/101", ok, bus.pending); end
        checks++; if (bus.moving !== 1'b1)    begin errors++; $display("FAIL mid_still_moving: got %b want 1", bus.moving); end
        wait_leds(3'b100, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1 || bus.pending !== 3'b001) begin errors++; $display("FAIL mid_f2: ok %b door %b pending %b want 1/1/001", ok, bus.door_open, bus.pending); end
        wait_door_closed(100, n);
        checks++; if (n !== 8)                begin errors++; $display("FAIL mid_door_len: got %0d want 8", n); end
        wait_moving(20, ok);
        checks++; if (!ok || bus.dir_up !== 1'b0) begin errors++; $display("FAIL mid_reverse: ok %b dir %b want 1/0", ok, bus.dir_up); end
        wait_leds(3'b010, 100, ok);
        checks++; if (!ok || bus.moving !== 1'b1 || bus.door_open !== 1'b0) begin errors++; $display("FAIL mid_pass_f1: ok %b moving %b door %b want 1/1/0", ok, bus.moving, bus.door_open); end
        wait_leds(3'b001, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1 || bus.pending !== 3'b000) begin errors++; $display("FAIL mid_f0: ok %b door %b pending %b want 1/1/000", ok, bus.door_open, bus.pending); end
        wait_door_closed(100, n);
    endtask

    task automatic test_all_calls();
        bit ok; int n;
        bus.call = 3'b010; step(); bus.call = 3'b000;
        wait_leds(3'b010, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1 || bus.dir_up !== 1'b1) begin errors++; $display("FAIL all_to_f1: ok %b door %b dir %b want 1/1/1", ok, bus.door_open, bus.dir_up); end
        wait_door_closed(100, n);
        bus.call = 3'b111; step(); bus.call = 3'b000;
        checks++; if (bus.door_open !== 1'b1 || leds !== 3'b010) begin errors++; $display("FAIL all_door_f1: door %b leds %b want 1/010", bus.door_open, leds); end
        checks++; if (bus.pending !== 3'b101) begin errors++; $display("FAIL all_pend1: got %b want 101", bus.pending); end
        wait_door_closed(100, n);
        checks++; if (n !== 8)                begin errors++; $display("FAIL all_door_len: got %0d want 8", n); end
        wait_leds(3'b100, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1 || bus.pending !== 3'b001) begin errors++; $display("FAIL all_f2: ok %b door %b pending %b want 1/1/001", ok, bus.door_open, bus.pending); end
        wait_door_closed(100, n);
        wait_leds(3'b001, 100, ok);
        checks++; if (!ok || bus.door_open !== 1'b1 || bus.pending !== 3'b000) begin errors++; $display("FAIL all_f0: ok %b door %b pending %b want 1/1/000", ok, bus.door_open, bus.pending); end
        wait_door_closed(100, n);
    endtask

    task automatic test_reset_mid();
        bit ok; bit moved;
        bus.call = 3'b010; step(); bus.call = 3'b000;
        wait_moving(20, ok);
        step();
        checks++; if (!ok || bus.moving !== 1'b1 || leds !== 3'b001 || bus.pending !== 3'b010) begin errors++; $display("FAIL rm_pre: ok %b moving %b leds %b pending %b want 1/1/001/010", ok, bus.moving, leds, bus.pending); end
        reset_n = 1'b0;
        #1;
        checks++; if (leds !== 3'b001 || bus.moving !== 1'b0) begin errors++; $display("FAIL rm_async: leds %b moving %b want 001/0", leds, bus.moving); end
        checks++; if (bus.pending !== 3'b000 || bus.door_open !== 1'b0) begin errors++; $display("FAIL rm_clear: pending %b door %b want 000/0", bus.pending, bus.door_open); end
        step();
        reset_n = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.moving !== 1'b0) moved = 1'b1;
        end
        checks++; if (moved !== 1'b0 || leds !== 3'b001) begin errors++; $display("FAIL rm_quiet: moved %b leds %b want 0/001", moved, leds); end
    endtask

    initial begin
        bus.call = 3'b000;
        test_reset();
        test_up_trip();
        test_down_pass();
        test_door_hold();
        test_midtravel_call();
        test_all_calls();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
